// File: rtl/cpu_wb_arbiter.sv
// Round-robin writeback arbiter: per-requester in-order FIFOs drained one entry per cycle
// onto a registered register-file write bus that idles at destination 0.
module cpu_wb_arbiter #(
  parameter  int regCount = 32,
  parameter  int NUM_REQ  = 3,
  parameter  int DEPTH    = 2,
  localparam int RW       = $clog2(regCount),
  localparam int SW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*RW-1:0] req_dest,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic [RW-1:0]         wb_d,
  output logic [31:0]           wb_data,
  output logic                  wb_valid,
  output logic [SW-1:0]         wb_src,
  output logic                  busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);
  localparam logic [SW-1:0] LAST_R  = SW'(NUM_REQ - 1);

  logic [RW-1:0] dest_mem_q [NUM_REQ][DEPTH];
  logic [31:0]   data_mem_q [NUM_REQ][DEPTH];
  logic [PW-1:0] wr_ptr_q [NUM_REQ];
  logic [PW-1:0] wr_ptr_d [NUM_REQ];
  logic [PW-1:0] rd_ptr_q [NUM_REQ];
  logic [PW-1:0] rd_ptr_d [NUM_REQ];
  logic [CW-1:0] count_q  [NUM_REQ];
  logic [CW-1:0] count_d  [NUM_REQ];
  logic [SW-1:0] rr_q, rr_d;

  logic          wb_valid_q, wb_valid_d;
  logic [RW-1:0] wb_d_q, wb_d_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic [SW-1:0] wb_src_q, wb_src_d;

  logic [NUM_REQ-1:0] push, pop, nonempty;
  logic               gnt_vld;
  logic [SW-1:0]      gnt_idx;
  logic [RW-1:0]      head_dest;
  logic [31:0]        head_data;
  int                 scan_idx;

  // Ready looks only at registered occupancy, so a full FIFO stays closed while being popped.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (count_q[i] < DEPTH_C) && !reset;
      nonempty[i]  = (count_q[i] != '0);
      push[i]      = req_valid[i] && req_ready[i] && (req_dest[i*RW +: RW] != '0);
    end
  end

  always_comb begin
    gnt_vld   = 1'b0;
    gnt_idx   = '0;
    head_dest = '0;
    head_data = '0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(rr_q) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!gnt_vld && nonempty[scan_idx]) begin
        gnt_vld   = 1'b1;
        gnt_idx   = SW'(scan_idx);
        head_dest = dest_mem_q[scan_idx][rd_ptr_q[scan_idx]];
        head_data = data_mem_q[scan_idx][rd_ptr_q[scan_idx]];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      pop[i] = gnt_vld && (gnt_idx == SW'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      count_d[i]  = count_q[i];
      if (push[i]) wr_ptr_d[i] = (wr_ptr_q[i] == LAST_P) ? '0 : wr_ptr_q[i] + 1'b1;
      if (pop[i])  rd_ptr_d[i] = (rd_ptr_q[i] == LAST_P) ? '0 : rd_ptr_q[i] + 1'b1;
      case ({push[i], pop[i]})
        2'b10:   count_d[i] = count_q[i] + 1'b1;
        2'b01:   count_d[i] = count_q[i] - 1'b1;
        default: count_d[i] = count_q[i];
      endcase
    end
    // Idle cycles drive destination 0 but keep data/source for a quieter bus.
    wb_valid_d = gnt_vld;
    wb_d_d     = gnt_vld ? head_dest : '0;
    wb_data_d  = gnt_vld ? head_data : wb_data_q;
    wb_src_d   = gnt_vld ? gnt_idx : wb_src_q;
    rr_d       = gnt_vld ? ((gnt_idx == LAST_R) ? '0 : gnt_idx + 1'b1) : rr_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      rr_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_d_q     <= '0;
      wb_data_q  <= '0;
      wb_src_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
      rr_q       <= rr_d;
      wb_valid_q <= wb_valid_d;
      wb_d_q     <= wb_d_d;
      wb_data_q  <= wb_data_d;
      wb_src_q   <= wb_src_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push[i]) begin
        dest_mem_q[i][wr_ptr_q[i]] <= req_dest[i*RW +: RW];
        data_mem_q[i][wr_ptr_q[i]] <= req_data[i*32 +: 32];
      end
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_d     = wb_d_q;
  assign wb_data  = wb_data_q;
  assign wb_src   = wb_src_q;
  assign busy     = wb_valid_q || (|nonempty);

endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// Directed and random bench for cpu_wb_arbiter against a queue-based model of the writeback rules.
module tb_cpu_wb_arbiter;
  localparam int NR = 3;
  localparam int RW = 5;
  localparam int DEPTH = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*RW-1:0] req_dest;
  logic [NR*32-1:0] req_data;
  logic [RW-1:0]    wb_d;
  logic [31:0]      wb_data;
  logic             wb_valid;
  logic [1:0]       wb_src;
  logic             busy;

  cpu_wb_arbiter #(.regCount(32), .NUM_REQ(NR), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_dest(req_dest), .req_data(req_data), .wb_d(wb_d), .wb_data(wb_data),
    .wb_valid(wb_valid), .wb_src(wb_src), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [RW-1:0] d; logic [31:0] x; } ent_t;
  typedef struct { int src; int d; logic [31:0] x; int cyc; } obs_t;

  ent_t          mq [NR][$];
  obs_t          log_q [$];
  int            m_rr, m_src, cyc, n_cmp, n_err;
  logic          m_v;
  logic [RW-1:0] m_d;
  logic [31:0]   m_x;
  logic [NR-1:0] m_acc, pre_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [NR-1:0] v, input int d0, input int d1, input int d2,
                       input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x2);
    req_valid = v;
    req_dest  = {RW'(d2), RW'(d1), RW'(d0)};
    req_data  = {x2, x1, x0};
  endtask

  // One clock: check ready mid-cycle, advance the model at the edge, check the bus just after.
  task automatic step();
    logic [NR-1:0] er;
    int g;
    ent_t e;
    logic any;
    #3;
    pre_rdy = req_ready;
    for (int i = 0; i < NR; i++) er[i] = !reset && (mq[i].size() < DEPTH);
    chk("req_ready", 32'(req_ready), 32'(er));
    m_acc = reset ? '0 : (req_valid & er);
    @(posedge clock);
    cyc++;
    if (reset) begin
      for (int i = 0; i < NR; i++) mq[i].delete();
      log_q.delete();
      m_rr = 0; m_v = 1'b0; m_d = '0; m_x = '0; m_src = 0;
    end else begin
      g = -1;
      for (int k = 0; k < NR; k++) begin
        if (g < 0 && mq[(m_rr + k) % NR].size() > 0) g = (m_rr + k) % NR;
      end
      if (g >= 0) begin
        e = mq[g].pop_front();
        m_v = 1'b1; m_d = e.d; m_x = e.x; m_src = g; m_rr = (g + 1) % NR;
      end else begin
        m_v = 1'b0; m_d = '0;
      end
      for (int i = 0; i < NR; i++)
        if (m_acc[i] && req_dest[i*RW +: RW] != '0)
          mq[i].push_back({req_dest[i*RW +: RW], req_data[i*32 +: 32]});
    end
    #1;
    any = m_v;
    for (int i = 0; i < NR; i++) if (mq[i].size() > 0) any = 1'b1;
    chk("wb_valid", 32'(wb_valid), 32'(m_v));
    chk("wb_d", 32'(wb_d), 32'(m_d));
    chk("wb_data", wb_data, m_x);
    chk("wb_src", 32'(wb_src), 32'(m_src));
    chk("busy", 32'(busy), 32'(any));
    if (wb_valid) log_q.push_back('{int'(wb_src), int'(wb_d), wb_data, cyc});
  endtask

  task automatic idle(input int n);
    drive('0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int idx, k, n;
    logic saw;
    n_cmp = 0; n_err = 0; cyc = 0;
    m_rr = 0; m_v = 1'b0; m_d = '0; m_x = '0; m_src = 0;
    reset = 1'b1;
    drive('0, 0, 0, 0, 0, 0, 0);
    step(); step();
    reset = 1'b0;

    // Single write latency
    drive(3'b001, 5, 0, 0, 32'hDEADBEEF, 0, 0);
    step();
    chk("t1_accept_idle", 32'(wb_valid), 0);
    idle(1);
    chk("t1_wb_valid", 32'(wb_valid), 1);
    chk("t1_wb_d", 32'(wb_d), 5);
    chk("t1_wb_data", wb_data, 32'hDEADBEEF);
    chk("t1_wb_src", 32'(wb_src), 0);
    idle(1);
    chk("t1_idle_d", 32'(wb_d), 0);
    chk("t1_idle_busy", 32'(busy), 0);

    // Round robin from rr=0, twice, then rr=2 with req 1 and 2 pending
    reset = 1'b1; step(); reset = 1'b0;
    for (int r = 0; r < 2; r++) begin
      drive(3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33);
      step();
      drive('0, 0, 0, 0, 0, 0, 0);
      for (int j = 0; j < NR; j++) begin
        step();
        chk("t2_src", 32'(wb_src), 32'(j));
        chk("t2_data", wb_data, 32'h11 * (j + 1));
      end
    end
    drive(3'b010, 0, 4, 0, 0, 32'h44, 0);
    step();
    idle(1);
    chk("t2_solo_src", 32'(wb_src), 1);
    drive(3'b110, 0, 6, 7, 0, 32'h66, 32'h77);
    step();
    idle(1);
    chk("t2_rr2_first", 32'(wb_src), 2);
    idle(1);
    chk("t2_rr2_second", 32'(wb_src), 1);
    idle(3);

    // Backpressure on requester 2 while 0 and 1 stay saturated
    log_q.delete(); idx = 0; saw = 1'b0;
    for (int c = 0; c < 40; c++) begin
      drive({1'(idx < 5), 2'b11}, $urandom_range(1, 31), $urandom_range(1, 31), idx + 1,
            $urandom, $urandom, 32'hC000_0000 + idx);
      step();
      if (m_acc[2] && idx < 5) idx++;
      if (!pre_rdy[2]) saw = 1'b1;
    end
    idle(10);
    k = 0;
    foreach (log_q[i]) if (log_q[i].src == 2) begin
      chk("t3_order", log_q[i].x, 32'hC000_0000 + k);
      k++;
    end
    chk("t3_count", k, 5);
    chk("t3_saw_not_ready", 32'(saw), 1);

    // Destination 0 is consumed but never written
    drive(3'b010, 0, 0, 0, 0, 32'hFFFFFFFF, 0);
    step();
    chk("t4_accepted", 32'(m_acc[1]), 1);
    idle(1);
    chk("t4_wb_valid", 32'(wb_valid), 0);
    chk("t4_wb_d", 32'(wb_d), 0);
    chk("t4_busy", 32'(busy), 0);

    // Reset mid-operation
    for (int c = 0; c < 4; c++) begin
      drive(3'b111, 8 + c, 12 + c, 16 + c, $urandom, $urandom, $urandom);
      step();
    end
    reset = 1'b1;
    drive('0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    #1;
    chk("t5_ready", 32'(req_ready), 32'h7);
    chk("t5_wb_valid", 32'(wb_valid), 0);
    chk("t5_busy", 32'(busy), 0);
    idle(5);
    chk("t5_stale", log_q.size(), 0);

    // Pointer wrap: ten writes through requester 0
    log_q.delete(); n = 0;
    for (int c = 0; c < 30; c++) begin
      drive({2'b00, 1'(n < 10)}, n + 1, 0, 0, 32'(n + 1), 0, 0);
      step();
      if (m_acc[0] && n < 10) n++;
    end
    chk("t6_sent", n, 10);
    chk("t6_count", log_q.size(), 10);
    if (log_q.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        chk("t6_d", 32'(log_q[i].d), 32'(i + 1));
        chk("t6_data", log_q[i].x, 32'(i + 1));
      end
      chk("t6_back_to_back", log_q[9].cyc - log_q[0].cyc, 9);
    end

    // Random traffic with occasional dest 0 and resets
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 39) == 0);
      req_valid = NR'($urandom);
      for (int i = 0; i < NR; i++)
        req_dest[i*RW +: RW] = ($urandom_range(0, 3) == 0) ? '0 : RW'($urandom);
      req_data = {$urandom, $urandom, $urandom};
      step();
    end
    reset = 1'b0;
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
